// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the register read path; FWFT head, 1-cycle write-to-read latency.
// Full pushes are dropped and latch a sticky overrun flag; the receiver is never stalled.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int THRESHOLD  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_overrun,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overrun,
  output logic                  irq
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_THR  = (ADDR_WIDTH+1)'(THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  overrun_q;

  logic pop_ok;
  logic push_ok;
  logic drop;

  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign pop_ok  = rd_en && (level_q != '0);
  assign push_ok = rx_valid && ((level_q != LVL_FULL) || pop_ok);
  assign drop    = rx_valid && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level_q <= level_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level_q <= level_q - 1'b1;
      end
      // A fresh drop outranks a software clear in the same cycle.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rd_data = (level_q != '0) ? mem[rd_ptr] : '0;
  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign level   = level_q;
  assign overrun = overrun_q;
  assign irq     = (level_q >= LVL_THR) || overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: linear steps with immediate assertions against hand-computed values.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_en;
  logic       flush;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .THRESHOLD (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rd_en      (rd_en),
    .flush      (flush),
    .clr_overrun(clr_overrun),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overrun    (overrun),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rd_en = 1'b0;
    flush = 1'b0; clr_overrun = 1'b0;

    // 1: reset state
    #3;
    chk("rst_empty",   32'(empty),   1);
    chk("rst_full",    32'(full),    0);
    chk("rst_level",   32'(level),   0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_irq",     32'(irq),     0);
    tick();
    rst = 1'b1;
    tick();

    // 2: two pushes, FWFT head, pops
    push(8'hA5);
    chk("p1_empty", 32'(empty), 0);
    chk("p1_rd_data", 32'(rd_data), 32'hA5);
    push(8'h3C);
    chk("p2_level", 32'(level), 2);
    chk("p2_rd_data", 32'(rd_data), 32'hA5);
    pop();
    chk("pop1_rd_data", 32'(rd_data), 32'h3C);
    chk("pop1_level", 32'(level), 1);
    pop();
    chk("pop2_empty", 32'(empty), 1);
    chk("pop2_rd_data", 32'(rd_data), 0);

    // 3: fill to full, irq at level 8, overrun on 17th push
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_irq", 32'(irq), (i + 1 >= 8) ? 1 : 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_overrun", 32'(overrun), 0);
    push(8'hFF);
    chk("ovr_overrun", 32'(overrun), 1);
    chk("ovr_level", 32'(level), 16);
    chk("ovr_rd_data", 32'(rd_data), 0);
    clr_overrun = 1'b1;
    push(8'hFE);
    clr_overrun = 1'b0;
    chk("clr_vs_drop_overrun", 32'(overrun), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_rd_data", 32'(rd_data), 32'(i));
      pop();
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_irq_ovr", 32'(irq), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_irq", 32'(irq), 0);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("full2", 32'(full), 1);
    rx_data = 8'h77; rx_valid = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    chk("pp_level", 32'(level), 16);
    chk("pp_overrun", 32'(overrun), 0);
    chk("pp_rd_data", 32'(rd_data), 32'h11);
    for (int i = 1; i < 16; i++) begin
      chk("pp_drain", 32'(rd_data), 32'(8'h10 + i));
      pop();
    end
    chk("pp_last", 32'(rd_data), 32'h77);
    pop();
    chk("pp_empty", 32'(empty), 1);

    // 5: pops on empty ignored, then push+pop on empty
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("epop_level", 32'(level), 0);
      chk("epop_empty", 32'(empty), 1);
    end
    rx_data = 8'h5A; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    chk("epp_level", 32'(level), 1);
    chk("epp_rd_data", 32'(rd_data), 32'h5A);

    // 6: level 5 with overrun, then flush with a same-cycle push
    for (int i = 0; i < 15; i++) push(8'(8'h60 + i));
    push(8'hEE);
    chk("f_pre_overrun", 32'(overrun), 1);
    for (int i = 0; i < 11; i++) pop();
    chk("f_pre_level", 32'(level), 5);
    chk("f_pre_rd_data", 32'(rd_data), 32'h6A);
    flush = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
    tick();
    flush = 1'b0; rx_valid = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_overrun", 32'(overrun), 0);
    chk("flush_irq", 32'(irq), 0);
    chk("flush_rd_data", 32'(rd_data), 0);

    // async reset in the middle of a burst
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(8'hC0 + i);
      tick();
    end
    chk("burst_level", 32'(level), 9);
    chk("burst_irq", 32'(irq), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_full", 32'(full), 0);
    rx_valid = 1'b0;
    tick();
    rst = 1'b1;
    push(8'h42);
    chk("post_rst_rd_data", 32'(rd_data), 32'h42);
    chk("post_rst_level", 32'(level), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
